// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter and its lane-alignment helper.
//   arb_state_t : arbiter FSM state encoding
//   W_BYTE/W_HALF/W_WORD : dmem_width encodings (2'b11 is handled as a word)
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } arb_state_t;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

endpackage

// File: rtl/mem_arbiter_lane_align.sv
// Combinational byte-lane alignment for sub-word memory accesses.
// Ports:
//   addr_i       : byte offset within the word (addr[1:0])
//   width_i      : access width (W_BYTE / W_HALF / W_WORD, 2'b11 = word)
//   store_i      : right-aligned store data
//   rdata_i      : raw word read from memory
//   strb_o       : byte enables for the access
//   wdata_o      : store data shifted into its byte lanes
//   load_o       : read data right-aligned and zero-padded above the width
//   misaligned_o : half on an odd address or word on a non-zero offset
module mem_arbiter_lane_align
  import mem_arbiter_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [1:0]  width_i,
  input  logic [31:0] store_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  strb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o,
  output logic        misaligned_o
);

  logic [4:0]  shamt;
  logic [31:0] mask;

  always_comb begin
    shamt        = {addr_i, 3'b000};
    strb_o       = 4'b1111;
    mask         = 32'hFFFF_FFFF;
    misaligned_o = 1'b0;
    unique case (width_i)
      W_BYTE: begin
        strb_o = 4'b0001 << addr_i;
        mask   = 32'h0000_00FF;
      end
      W_HALF: begin
        strb_o       = 4'b0011 << {addr_i[1], 1'b0};
        mask         = 32'h0000_FFFF;
        misaligned_o = addr_i[0];
      end
      default: begin
        strb_o       = 4'b1111;
        mask         = 32'hFFFF_FFFF;
        misaligned_o = |addr_i;
      end
    endcase
    wdata_o = store_i << shamt;
    load_o  = (rdata_i >> shamt) & mask;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported word memory between instruction fetch and data access.
// Data requests win; each access runs IDLE -> ACCESS -> DONE, with misaligned data
// accesses short-circuiting IDLE -> DONE. All outputs are registered.
// Ports:
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   imem_ren_i/imem_addr_i  : fetch request (held until ihit_o), word address
//   imem_load_o, ihit_o     : fetched word, fetch-complete pulse
//   dmem_ren_i/dmem_wen_i   : data read/write request (held until dhit_o)
//   dmem_addr_i/_width_i    : byte address and access width
//   dmem_store_i            : right-aligned store data
//   dmem_load_o, dhit_o     : right-aligned load data, data-complete pulse
//   bus_err_o               : pulses with a hit when the access failed
//   ram_*                   : memory-side strobes, address, data, byte enables
//   ram_rdata_i/ram_ready_i : memory read data and completion
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        imem_ren_i,
  input  logic [31:0] imem_addr_i,
  output logic [31:0] imem_load_o,
  output logic        ihit_o,
  input  logic        dmem_ren_i,
  input  logic        dmem_wen_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [1:0]  dmem_width_i,
  input  logic [31:0] dmem_store_i,
  output logic [31:0] dmem_load_o,
  output logic        dhit_o,
  output logic        bus_err_o,
  output logic        ram_ren_o,
  output logic        ram_wen_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  output logic [3:0]  ram_strb_o,
  input  logic [31:0] ram_rdata_i,
  input  logic        ram_ready_i
);

  arb_state_t  state_q;
  logic        is_data_q;
  logic        write_q;
  logic [1:0]  addr_lo_q;
  logic [1:0]  width_q;
  logic [31:0] cnt_q;
  logic        ram_ren_q;
  logic        ram_wen_q;
  logic [31:0] ram_addr_q;
  logic [31:0] ram_wdata_q;
  logic [3:0]  ram_strb_q;
  logic        ihit_q;
  logic        dhit_q;
  logic        bus_err_q;
  logic [31:0] imem_load_q;
  logic [31:0] dmem_load_q;

  logic        d_req;
  logic [1:0]  la_addr;
  logic [1:0]  la_width;
  logic [3:0]  la_strb;
  logic [31:0] la_wdata;
  logic [31:0] la_load;
  logic        la_misaligned;
  logic        timed_out;
  logic        unused_imem_lsb;

  // Fetch addresses are word addresses; the byte offset is deliberately dropped.
  assign unused_imem_lsb = ^imem_addr_i[1:0];

  assign d_req = dmem_ren_i | dmem_wen_i;

  // In IDLE the aligner sees the incoming request (strobes/misalignment are
  // registered on entry to ACCESS); afterwards it sees the latched access so
  // the returning read data is aligned with the original offset and width.
  always_comb begin
    la_addr  = addr_lo_q;
    la_width = width_q;
    if (state_q == StIdle) begin
      la_addr  = d_req ? dmem_addr_i[1:0] : 2'b00;
      la_width = d_req ? dmem_width_i : W_WORD;
    end
  end

  mem_arbiter_lane_align u_lane_align (
    .addr_i       (la_addr),
    .width_i      (la_width),
    .store_i      (dmem_store_i),
    .rdata_i      (ram_rdata_i),
    .strb_o       (la_strb),
    .wdata_o      (la_wdata),
    .load_o       (la_load),
    .misaligned_o (la_misaligned)
  );

  assign timed_out = (TIMEOUT != 0) && (cnt_q == TIMEOUT - 1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      is_data_q   <= 1'b0;
      write_q     <= 1'b0;
      addr_lo_q   <= 2'b00;
      width_q     <= W_WORD;
      cnt_q       <= '0;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_strb_q  <= '0;
      ihit_q      <= 1'b0;
      dhit_q      <= 1'b0;
      bus_err_q   <= 1'b0;
      imem_load_q <= '0;
      dmem_load_q <= '0;
    end else begin
      ihit_q    <= 1'b0;
      dhit_q    <= 1'b0;
      bus_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (d_req) begin
            is_data_q  <= 1'b1;
            write_q    <= dmem_wen_i;
            addr_lo_q  <= dmem_addr_i[1:0];
            width_q    <= dmem_width_i;
            ram_addr_q <= {dmem_addr_i[31:2], 2'b00};
            if (la_misaligned) begin
              state_q     <= StDone;
              dhit_q      <= 1'b1;
              bus_err_q   <= 1'b1;
              dmem_load_q <= '0;
            end else begin
              state_q     <= StAccess;
              ram_ren_q   <= ~dmem_wen_i;
              ram_wen_q   <= dmem_wen_i;
              ram_strb_q  <= dmem_wen_i ? la_strb : 4'b0000;
              ram_wdata_q <= la_wdata;
            end
          end else if (imem_ren_i) begin
            is_data_q  <= 1'b0;
            write_q    <= 1'b0;
            addr_lo_q  <= 2'b00;
            width_q    <= W_WORD;
            ram_addr_q <= {imem_addr_i[31:2], 2'b00};
            state_q    <= StAccess;
            ram_ren_q  <= 1'b1;
            ram_wen_q  <= 1'b0;
            ram_strb_q <= 4'b0000;
          end
        end
        StAccess: begin
          if (ram_ready_i || timed_out) begin
            state_q    <= StDone;
            ram_ren_q  <= 1'b0;
            ram_wen_q  <= 1'b0;
            ram_strb_q <= 4'b0000;
            bus_err_q  <= ~ram_ready_i;
            if (is_data_q) begin
              dhit_q <= 1'b1;
              if (!ram_ready_i) begin
                dmem_load_q <= '0;
              end else if (!write_q) begin
                dmem_load_q <= la_load;
              end
            end else begin
              ihit_q      <= 1'b1;
              imem_load_q <= ram_ready_i ? la_load : 32'h0;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        // One dead cycle so the datapath can drop its held request after the hit.
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign imem_load_o = imem_load_q;
  assign ihit_o      = ihit_q;
  assign dmem_load_o = dmem_load_q;
  assign dhit_o      = dhit_q;
  assign bus_err_o   = bus_err_q;
  assign ram_ren_o   = ram_ren_q;
  assign ram_wen_o   = ram_wen_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign ram_strb_o  = ram_strb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (built with TIMEOUT = 4).
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic [31:0] imem_load;
  logic        ihit;
  logic        dmem_ren;
  logic        dmem_wen;
  logic [31:0] dmem_addr;
  logic [1:0]  dmem_width;
  logic [31:0] dmem_store;
  logic [31:0] dmem_load;
  logic        dhit;
  logic        bus_err;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_strb;
  logic [31:0] ram_rdata;
  logic        ram_ready;
  logic        ready_en;

  int n_checks = 0;
  int n_pass   = 0;

  // Zero-wait RAM when enabled; never answers when disabled.
  assign ram_ready = ready_en & (ram_ren | ram_wen);

  mem_arbiter #(
    .TIMEOUT (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .imem_ren_i   (imem_ren),
    .imem_addr_i  (imem_addr),
    .imem_load_o  (imem_load),
    .ihit_o       (ihit),
    .dmem_ren_i   (dmem_ren),
    .dmem_wen_i   (dmem_wen),
    .dmem_addr_i  (dmem_addr),
    .dmem_width_i (dmem_width),
    .dmem_store_i (dmem_store),
    .dmem_load_o  (dmem_load),
    .dhit_o       (dhit),
    .bus_err_o    (bus_err),
    .ram_ren_o    (ram_ren),
    .ram_wen_o    (ram_wen),
    .ram_addr_o   (ram_addr),
    .ram_wdata_o  (ram_wdata),
    .ram_strb_o   (ram_strb),
    .ram_rdata_i  (ram_rdata),
    .ram_ready_i  (ram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    imem_ren = 1'b0;
    dmem_ren = 1'b0;
    dmem_wen = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    imem_ren   = 1'b0;
    imem_addr  = '0;
    dmem_ren   = 1'b0;
    dmem_wen   = 1'b0;
    dmem_addr  = '0;
    dmem_width = 2'b10;
    dmem_store = '0;
    ram_rdata  = '0;
    ready_en   = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;

    // Reset state
    check("rst_ram_ren", {31'b0, ram_ren}, 32'd0);
    check("rst_ram_wen", {31'b0, ram_wen}, 32'd0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_strb", {28'b0, ram_strb}, 32'h0);
    check("rst_hits", {29'b0, ihit, dhit, bus_err}, 32'd0);
    check("rst_imem_load", imem_load, 32'h0);
    check("rst_dmem_load", dmem_load, 32'h0);

    // Fetch, zero-wait RAM
    ram_rdata = 32'h0050_0093;
    imem_addr = 32'h100;
    imem_ren  = 1'b1;
    cyc();
    check("f_c1_ren", {31'b0, ram_ren}, 32'd1);
    check("f_c1_addr", ram_addr, 32'h100);
    check("f_c1_ihit", {31'b0, ihit}, 32'd0);
    cyc();
    check("f_c2_ihit", {31'b0, ihit}, 32'd1);
    check("f_c2_load", imem_load, 32'h0050_0093);
    check("f_c2_err", {31'b0, bus_err}, 32'd0);
    check("f_c2_ren", {31'b0, ram_ren}, 32'd0);
    idle_inputs();
    cyc();

    // Data beats fetch when both raised together
    ram_rdata  = 32'h1122_3344;
    imem_addr  = 32'h104;
    imem_ren   = 1'b1;
    dmem_addr  = 32'h300;
    dmem_width = 2'b10;
    dmem_ren   = 1'b1;
    cyc();
    check("p_c1_addr", ram_addr, 32'h300);
    check("p_c1_ren", {31'b0, ram_ren}, 32'd1);
    cyc();
    check("p_c2_dhit", {31'b0, dhit, ihit}, 32'b10);
    check("p_c2_dload", dmem_load, 32'h1122_3344);
    dmem_ren  = 1'b0;
    ram_rdata = 32'hCAFE_F00D;
    cyc();
    check("p_c3_idle", {30'b0, ram_ren, ihit}, 32'd0);
    cyc();
    check("p_c4_addr", ram_addr, 32'h104);
    check("p_c4_ren", {30'b0, ram_ren, ihit}, 32'b10);
    cyc();
    check("p_c5_ihit", {31'b0, ihit}, 32'd1);
    check("p_c5_iload", imem_load, 32'hCAFE_F00D);
    check("p_c5_dhold", dmem_load, 32'h1122_3344);
    idle_inputs();
    cyc();

    // Byte store 0xAB to 0x203
    dmem_addr  = 32'h203;
    dmem_width = 2'b00;
    dmem_store = 32'h0000_00AB;
    dmem_wen   = 1'b1;
    cyc();
    check("sb_wen", {30'b0, ram_wen, ram_ren}, 32'b10);
    check("sb_strb", {28'b0, ram_strb}, 32'b1000);
    check("sb_addr", ram_addr, 32'h200);
    check("sb_wdata", ram_wdata, 32'hAB00_0000);
    cyc();
    check("sb_dhit", {30'b0, dhit, bus_err}, 32'b10);
    idle_inputs();
    cyc();

    // Half store 0x5678 to 0x202
    dmem_addr  = 32'h202;
    dmem_width = 2'b01;
    dmem_store = 32'h0000_5678;
    dmem_wen   = 1'b1;
    cyc();
    check("sh_strb", {28'b0, ram_strb}, 32'b1100);
    check("sh_wdata", ram_wdata, 32'h5678_0000);
    cyc();
    idle_inputs();
    cyc();

    // Half load from 0x202
    ram_rdata  = 32'hBEEF_1234;
    dmem_addr  = 32'h202;
    dmem_width = 2'b01;
    dmem_ren   = 1'b1;
    cyc();
    check("lh_ren", {30'b0, ram_ren, ram_wen}, 32'b10);
    check("lh_addr", ram_addr, 32'h200);
    cyc();
    check("lh_dhit", {30'b0, dhit, bus_err}, 32'b10);
    check("lh_load", dmem_load, 32'h0000_BEEF);
    idle_inputs();
    cyc();

    // Byte load from 0x201
    dmem_addr  = 32'h201;
    dmem_width = 2'b00;
    dmem_ren   = 1'b1;
    cyc();
    cyc();
    check("lb_load", dmem_load, 32'h0000_0012);
    idle_inputs();
    cyc();

    // Misaligned word load from 0x206
    dmem_addr  = 32'h206;
    dmem_width = 2'b10;
    dmem_ren   = 1'b1;
    cyc();
    check("mis_strobe", {30'b0, ram_ren, ram_wen}, 32'd0);
    check("mis_hit_err", {30'b0, dhit, bus_err}, 32'b11);
    check("mis_load", dmem_load, 32'h0);
    idle_inputs();
    cyc();
    check("mis_err_pulse", {30'b0, dhit, bus_err}, 32'd0);

    // Timeout with TIMEOUT = 4
    ready_en   = 1'b0;
    ram_rdata  = 32'h0F0F_0F0F;
    dmem_addr  = 32'h400;
    dmem_width = 2'b10;
    dmem_ren   = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check($sformatf("to_c%0d_ren", i), {30'b0, ram_ren, dhit}, 32'b10);
    end
    cyc();
    check("to_c5_ren", {31'b0, ram_ren}, 32'd0);
    check("to_c5_hit_err", {30'b0, dhit, bus_err}, 32'b11);
    check("to_c5_load", dmem_load, 32'h0);
    idle_inputs();
    ready_en = 1'b1;
    cyc();
    dmem_addr = 32'h404;
    dmem_ren  = 1'b1;
    cyc();
    check("to_next_addr", ram_addr, 32'h404);
    cyc();
    check("to_next_hit", {30'b0, dhit, bus_err}, 32'b10);
    check("to_next_load", dmem_load, 32'h0F0F_0F0F);
    idle_inputs();
    cyc();

    // Reset asserted mid-access
    ready_en  = 1'b0;
    imem_addr = 32'h108;
    imem_ren  = 1'b1;
    cyc();
    check("rs_c1_ren", {31'b0, ram_ren}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rs_ren_drop", {31'b0, ram_ren}, 32'd0);
    check("rs_addr", ram_addr, 32'h0);
    check("rs_loads", imem_load | dmem_load, 32'h0);
    check("rs_hits", {29'b0, ihit, dhit, bus_err}, 32'd0);
    cyc();
    rst      = 1'b0;
    ready_en = 1'b1;
    cyc();
    check("rs_restart_ren", {31'b0, ram_ren}, 32'd1);
    check("rs_restart_addr", ram_addr, 32'h108);
    cyc();
    check("rs_restart_ihit", {31'b0, ihit}, 32'd1);
    idle_inputs();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
